// File: rtl/branch_pc_unit_if.sv
// Port bundle between the D-stage decode/compare logic and the fetch PC unit.
// Flow control: there is no valid/ready pair; stall=1 means every other input is ignored that cycle.
interface branch_pc_unit_if;
  logic        stall;
  logic [31:0] d_pc;
  logic        is_branch;
  logic        br;
  logic [15:0] imm16;
  logic        is_j;
  logic [25:0] instr_index;
  logic        is_jr;
  logic [31:0] jr_target;
  logic [31:0] pc_f;
  logic [31:0] pc_plus8_d;
  logic        flush_d;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;
  logic        adel_f;

  modport master (
    output stall, d_pc, is_branch, br, imm16, is_j, instr_index, is_jr, jr_target,
    input  pc_f, pc_plus8_d, flush_d, br_cnt, taken_cnt, adel_f
  );

  modport slave (
    input  stall, d_pc, is_branch, br, imm16, is_j, instr_index, is_jr, jr_target,
    output pc_f, pc_plus8_d, flush_d, br_cnt, taken_cnt, adel_f
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch-stage PC register with next-PC select, branch statistics and sticky misaligned-fetch flag.
// Optional macro BRANCH_PC_DELAY_SLOT_EN: keep delay slots (flush_d tied low) instead of squashing them.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset_n,
  branch_pc_unit_if.slave   bus
);

  logic [31:0] pc_q;
  logic [31:0] br_cnt_q;
  logic [31:0] taken_cnt_q;
  logic        adel_q;

  logic [31:0] d_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        br_taken;
  logic [31:0] next_pc;

  assign d_pc_plus4 = bus.d_pc + 32'd4;
  assign br_offset  = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_target  = d_pc_plus4 + br_offset;
  assign j_target   = {d_pc_plus4[31:28], bus.instr_index, 2'b00};
  assign br_taken   = bus.is_branch & bus.br;

  // Overlapping decode flags are resolved by this order rather than flagged.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (bus.is_jr) begin
      next_pc = bus.jr_target;
    end else if (bus.is_j) begin
      next_pc = j_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
      adel_q      <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= next_pc;
      if (bus.is_branch && (br_cnt_q != 32'hFFFF_FFFF)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (br_taken && (taken_cnt_q != 32'hFFFF_FFFF)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
      if (next_pc[1:0] != 2'b00) begin
        adel_q <= 1'b1;
      end
    end
  end

  assign bus.pc_f       = pc_q;
  assign bus.pc_plus8_d = bus.d_pc + 32'd8;
  assign bus.br_cnt     = br_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;
  assign bus.adel_f     = adel_q;

`ifdef BRANCH_PC_DELAY_SLOT_EN
  assign bus.flush_d = 1'b0;
`else
  // Squash the sequential fetch that is already on its way into D.
  logic redir;
  assign redir       = (bus.is_jr | bus.is_j | br_taken) & ~bus.stall;
  assign bus.flush_d = redir & reset_n;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: abstract next-PC model checked every cycle plus literal pins.
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef BRANCH_PC_DELAY_SLOT_EN
  localparam bit FLUSH_ON_REDIR = 1'b0;
`else
  localparam bit FLUSH_ON_REDIR = 1'b1;
`endif

  logic clk;
  logic reset_n;
  branch_pc_unit_if bus();

  branch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [31:0] m_pc, m_br, m_tk;
  logic        m_adel;
  logic        m_valid = 1'b0;
  logic        preload_req = 1'b0;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    longint unsigned v;
    v = longint'(x) + 1;
    if (v > 64'd4294967295) v = 64'd4294967295;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur);
    longint signed off;
    logic [31:0] t;
    off = longint'($signed(bus.imm16)) * 4;
    if (bus.is_jr) t = bus.jr_target;
    else if (bus.is_j) t = ((bus.d_pc + 32'd4) & 32'hF000_0000) | (32'(bus.instr_index) * 32'd4);
    else if (bus.is_branch && bus.br) t = 32'(longint'(bus.d_pc) + 4 + off);
    else t = cur + 32'd4;
    return t;
  endfunction

  always @(posedge clk) begin
    logic [31:0] nxt;
    nxt = model_next(m_pc);
    if (!reset_n) begin
      m_pc    <= RST_PC;
      m_br    <= 32'd0;
      m_tk    <= 32'd0;
      m_adel  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid && !bus.stall) begin
      m_pc <= nxt;
      if (bus.is_branch) m_br <= sat_inc(m_br);
      if (bus.is_branch && bus.br) m_tk <= sat_inc(m_tk);
      if ((nxt % 4) != 0) m_adel <= 1'b1;
    end
    if (preload_req) begin
      m_br <= 32'hFFFF_FFFE;
      m_tk <= 32'hFFFF_FFFE;
    end
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;

  logic        lit_pc_en = 0, lit_cnt_en = 0, lit_adel_en = 0, lit_fl_en = 0;
  logic [31:0] lit_pc, lit_br, lit_tk;
  logic        lit_adel, lit_fl;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic exp_fl;
    if (m_valid) begin
      exp_fl = FLUSH_ON_REDIR && reset_n && !bus.stall &&
               (bus.is_jr || bus.is_j || (bus.is_branch && bus.br));
      check("pc_f", bus.pc_f, m_pc);
      check("br_cnt", bus.br_cnt, m_br);
      check("taken_cnt", bus.taken_cnt, m_tk);
      check("adel_f", 32'(bus.adel_f), 32'(m_adel));
      check("flush_d", 32'(bus.flush_d), 32'(exp_fl));
      check("pc_plus8_d", bus.pc_plus8_d, bus.d_pc + 32'd8);
      check("taken_le_br", 32'(bus.taken_cnt <= bus.br_cnt), 32'd1);
      if (lit_pc_en) check("lit_pc_f", bus.pc_f, lit_pc);
      if (lit_cnt_en) begin
        check("lit_br_cnt", bus.br_cnt, lit_br);
        check("lit_taken_cnt", bus.taken_cnt, lit_tk);
      end
      if (lit_adel_en) check("lit_adel_f", 32'(bus.adel_f), 32'(lit_adel));
      if (lit_fl_en) check("lit_flush_d", 32'(bus.flush_d), 32'(lit_fl));
      while (exp_q.size() > 0) check("lit_pc_plus8_d", bus.pc_plus8_d, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lit_pc_en = 0; lit_cnt_en = 0; lit_adel_en = 0; lit_fl_en = 0;
  endtask

  task automatic idle();
    bus.stall = 0; bus.d_pc = 32'h0; bus.is_branch = 0; bus.br = 0; bus.imm16 = 16'h0;
    bus.is_j = 0; bus.instr_index = 26'h0; bus.is_jr = 0; bus.jr_target = 32'h0;
  endtask

  task automatic exp_pc(input logic [31:0] v);
    lit_pc_en = 1; lit_pc = v;
  endtask

  task automatic exp_cnt(input logic [31:0] b, input logic [31:0] t);
    lit_cnt_en = 1; lit_br = b; lit_tk = t;
  endtask

  task automatic exp_adel(input logic v);
    lit_adel_en = 1; lit_adel = v;
  endtask

  task automatic exp_fl(input logic v);
    lit_fl_en = 1; lit_fl = v;
  endtask

  initial begin
    idle();
    reset_n = 0;
    // reset with a jump and a taken branch presented: must be ignored
    bus.is_j = 1; bus.is_branch = 1; bus.br = 1; bus.d_pc = 32'h3020;
    tick();
    exp_pc(RST_PC); exp_cnt(0, 0); exp_adel(0); exp_fl(0);
    tick();
    reset_n = 1; idle();
    exp_pc(32'h3000); exp_cnt(0, 0); exp_adel(0); tick();
    exp_pc(32'h3004); tick();
    exp_pc(32'h3008); tick();

    // taken beq backwards
    bus.d_pc = 32'h3010; bus.is_branch = 1; bus.br = 1; bus.imm16 = 16'hFFFC;
    exp_pc(32'h300C); exp_fl(FLUSH_ON_REDIR); exp_q.push_back(32'h3018);
    tick();
    // not-taken branch
    idle(); bus.d_pc = 32'h3004; bus.is_branch = 1; bus.br = 0; bus.imm16 = 16'h0040;
    exp_pc(32'h3004); exp_cnt(1, 1); exp_fl(0);
    tick();

    // stall with jump and taken branch presented
    idle(); bus.stall = 1; bus.is_j = 1; bus.is_branch = 1; bus.br = 1;
    bus.d_pc = 32'h3020; bus.instr_index = 26'h0000C10;
    for (int i = 0; i < 3; i++) begin
      exp_pc(32'h3008); exp_cnt(2, 1); exp_fl(0);
      tick();
    end
    // release: j evaluated with current inputs
    idle(); bus.is_j = 1; bus.d_pc = 32'h3020; bus.instr_index = 26'h0000C10;
    exp_pc(32'h3008); exp_cnt(2, 1); exp_fl(FLUSH_ON_REDIR);
    tick();
    // forward branch
    idle(); bus.d_pc = 32'h3040; bus.is_branch = 1; bus.br = 1; bus.imm16 = 16'h0010;
    exp_pc(32'h3040);
    tick();

    // jr beats branch, misaligned target
    idle(); bus.is_jr = 1; bus.is_branch = 1; bus.br = 1; bus.jr_target = 32'h0000_3006;
    bus.d_pc = 32'h3084; bus.imm16 = 16'h0100;
    exp_pc(32'h3084); exp_adel(0); exp_cnt(3, 2);
    tick();
    idle();
    exp_pc(32'h3006); exp_adel(1); exp_cnt(4, 3); tick();
    exp_pc(32'h300A); exp_adel(1); tick();

    // j target upper bits taken from wrapped d_pc+4
    bus.is_j = 1; bus.d_pc = 32'hFFFF_FFFC; bus.instr_index = 26'h3FF_FFFF;
    exp_q.push_back(32'h0000_0004);
    tick();
    idle(); exp_pc(32'h0FFF_FFFC); tick();
    // branch target wraps past 2^32
    bus.d_pc = 32'hFFFF_FFF8; bus.is_branch = 1; bus.br = 1; bus.imm16 = 16'h0004;
    tick();
    idle(); exp_pc(32'h0000_000C); exp_cnt(5, 4); exp_adel(1); tick();

    // saturation: preload both counters just below the ceiling
    bus.stall = 1; preload_req = 1;
    tick();
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    preload_req = 0;
    idle(); bus.d_pc = 32'h3000; bus.is_branch = 1; bus.br = 1;
    exp_cnt(32'hFFFF_FFFE, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) tick();
    idle(); exp_cnt(32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();

    // reset coincident with a taken branch
    reset_n = 0; bus.d_pc = 32'h3010; bus.is_branch = 1; bus.br = 1; bus.imm16 = 16'hFFFC;
    exp_fl(0);
    tick();
    reset_n = 1; idle();
    exp_pc(32'h3000); exp_cnt(0, 0); exp_adel(0); exp_fl(0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
